// File: rtl/processor_input_pkg.sv
// Shared constants for the processor_input single-cycle MIPS-subset core:
// opcodes, R-type function codes, ALU operation codes and ALU-op classes.
// It also holds the ALU control decoder and the ALU itself. Both are pure
// functions, so the top keeps them inline as combinational logic.
package processor_input_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // aluop 11 is never produced by the decoder; it falls back to add.
    function automatic logic [3:0] alu_control(input logic [1:0] aluop,
                                               input logic [5:0] funct);
        logic [3:0] con;
        con = ALU_ADD;
        if (aluop == ALUOP_SUB) begin
            con = ALU_SUB;
        end else if (aluop == ALUOP_FUNCT) begin
            case (funct)
                FUNCT_ADD: con = ALU_ADD;
                FUNCT_SUB: con = ALU_SUB;
                FUNCT_AND: con = ALU_AND;
                FUNCT_OR:  con = ALU_OR;
                FUNCT_SLT: con = ALU_SLT;
                FUNCT_NOR: con = ALU_NOR;
                default:   con = ALU_ADD;
            endcase
        end
        return con;
    endfunction

    // 32-bit wrapping ALU. slt compares as two's-complement.
    function automatic logic [31:0] alu_result(input logic [3:0]  con,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] a_s;
        logic signed [31:0] b_s;
        logic        [31:0] res;
        a_s = a;
        b_s = b;
        case (con)
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_SLT: res = (a_s < b_s) ? 32'd1 : 32'd0;
            ALU_NOR: res = ~(a | b);
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/processor_input_reg_file.sv
// 32 x 32 register file.
//   clk, reset             : rising-edge clock, synchronous active-high clear
//   rd_addr_a / rd_addr_b  : combinational read addresses (rs / rt)
//   rd_data_a / rd_data_b  : read data; register 0 always reads zero
//   wr_en, wr_addr, wr_data: synchronous write port; writes to r0 dropped
// A read of the register being written returns the old value. The new value
// is visible on the next cycle.
module processor_input_reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b
);

    logic [31:0] regs_q [32];

    assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : regs_q[rd_addr_b];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/processor_input.sv
// Single-cycle MIPS-subset core. It contains the instruction ROM, the
// register file, the ALU and the data RAM, and it completes one instruction
// per clock cycle.
//   clk, reset : rising-edge clock, synchronous active-high reset
//                (PC, registers and RAM cleared)
//   all other ports are outputs that expose the datapath and control
//   signals: PC, PC+4, instruction, register reads, immediate, ALU
//   operands/result, memory read, branch/jump targets, write-back
//   selection and decoded control bits.
// The ROM (64 words) powers up as zeros. The program image (instr.hex) is
// placed into instr_rom by the memory-initialisation flow of the
// surrounding environment.
module processor_input (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    output logic [31:0] PC4,
    output logic [31:0] instruction,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [31:0] bitOutSignExtened,
    output logic [31:0] outmux,
    output logic [3:0]  ALUCon,
    output logic [31:0] outALU,
    output logic        zero,
    output logic [31:0] dataOut,
    output logic [31:0] shiftBranch,
    output logic [31:0] addAddress,
    output logic        selBranch,
    output logic [31:0] jumpAddress,
    output logic [4:0]  wrRegis,
    output logic [31:0] dataToReg,
    output logic        regdst,
    output logic        alusrc,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        jump,
    output logic        jal,
    output logic [1:0]  aluop
);
    import processor_input_pkg::*;

    logic [31:0] instr_rom [64] = '{default: 32'd0};
    logic [31:0] ram_q [64];
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        branch_eq;
    logic        branch_ne;

    assign address     = pc_q;
    assign PC4         = pc_q + 32'd4;
    assign instruction = instr_rom[pc_q[7:2]];

    always_comb begin
        regdst    = 1'b0;
        alusrc    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        jump      = 1'b0;
        jal       = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        aluop     = ALUOP_ADD;
        case (instruction[31:26])
            OP_RTYPE: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                alusrc   = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
                memread  = 1'b1;
            end
            OP_SW: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            OP_BEQ: begin
                branch_eq = 1'b1;
                aluop     = ALUOP_SUB;
            end
            OP_BNE: begin
                branch_ne = 1'b1;
                aluop     = ALUOP_SUB;
            end
            OP_ADDI: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            OP_JAL: begin
                jump     = 1'b1;
                jal      = 1'b1;
                regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    processor_input_reg_file u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (instruction[25:21]),
        .rd_addr_b (instruction[20:16]),
        .wr_en     (regwrite),
        .wr_addr   (wrRegis),
        .wr_data   (dataToReg),
        .rd_data_a (data1),
        .rd_data_b (data2)
    );

    assign bitOutSignExtened = {{16{instruction[15]}}, instruction[15:0]};
    assign outmux            = alusrc ? bitOutSignExtened : data2;
    assign ALUCon            = alu_control(aluop, instruction[5:0]);
    assign outALU            = alu_result(ALUCon, data1, outmux);
    assign zero              = (outALU == 32'd0);
    assign dataOut           = ram_q[outALU[7:2]];

    assign shiftBranch = {bitOutSignExtened[29:0], 2'b00};
    assign addAddress  = PC4 + shiftBranch;
    assign selBranch   = (branch_eq & zero) | (branch_ne & ~zero);
    assign jumpAddress = {PC4[31:28], instruction[25:0], 2'b00};

    assign wrRegis   = jal ? 5'd31 : (regdst ? instruction[15:11] : instruction[20:16]);
    assign dataToReg = jal ? PC4 : (memtoreg ? dataOut : outALU);

    // Jump has priority over a taken branch.
    always_comb begin
        pc_d = PC4;
        if (jump) begin
            pc_d = jumpAddress;
        end else if (selBranch) begin
            pc_d = addAddress;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= 32'd0;
            for (int i = 0; i < 64; i++) begin
                ram_q[i] <= 32'd0;
            end
        end else begin
            pc_q <= pc_d;
            if (memwrite) begin
                ram_q[outALU[7:2]] <= data2;
            end
        end
    end

endmodule

// File: tb/tb_processor_input.sv
module tb_processor_input;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address, PC4, instruction, data1, data2, bitOutSignExtened;
    logic [31:0] outmux, outALU, dataOut, shiftBranch, addAddress;
    logic [31:0] jumpAddress, dataToReg;
    logic [3:0]  ALUCon;
    logic [4:0]  wrRegis;
    logic [1:0]  aluop;
    logic        zero, selBranch, regdst, alusrc, memtoreg, regwrite;
    logic        memread, memwrite, jump, jal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    processor_input dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .PC4               (PC4),
        .instruction       (instruction),
        .data1             (data1),
        .data2             (data2),
        .bitOutSignExtened (bitOutSignExtened),
        .outmux            (outmux),
        .ALUCon            (ALUCon),
        .outALU            (outALU),
        .zero              (zero),
        .dataOut           (dataOut),
        .shiftBranch       (shiftBranch),
        .addAddress        (addAddress),
        .selBranch         (selBranch),
        .jumpAddress       (jumpAddress),
        .wrRegis           (wrRegis),
        .dataToReg         (dataToReg),
        .regdst            (regdst),
        .alusrc            (alusrc),
        .memtoreg          (memtoreg),
        .regwrite          (regwrite),
        .memread           (memread),
        .memwrite          (memwrite),
        .jump              (jump),
        .jal               (jal),
        .aluop             (aluop)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nz;
        #1;
        for (int i = 0; i < 64; i++) dut.instr_rom[i] = 32'd0;
        dut.instr_rom[6'h00] = 32'h20010005; // addi $1,$0,5
        dut.instr_rom[6'h01] = 32'h20020003; // addi $2,$0,3
        dut.instr_rom[6'h02] = 32'h00221822; // sub  $3,$1,$2
        dut.instr_rom[6'h03] = 32'h0041202A; // slt  $4,$2,$1
        dut.instr_rom[6'h04] = 32'h00002827; // nor  $5,$0,$0
        dut.instr_rom[6'h05] = 32'hAC010008; // sw   $1,8($0)
        dut.instr_rom[6'h06] = 32'h8C060008; // lw   $6,8($0)
        dut.instr_rom[6'h07] = 32'h00223824; // and  $7,$1,$2
        dut.instr_rom[6'h08] = 32'h10210002; // 0x20 beq $1,$1,+2
        dut.instr_rom[6'h0A] = 32'h20090001; // 0x28 addi $9,$0,1 (skipped)
        dut.instr_rom[6'h0B] = 32'h14210002; // 0x2C bne $1,$1,+2
        dut.instr_rom[6'h0C] = 32'h0C000010; // 0x30 jal 0x10
        dut.instr_rom[6'h10] = 32'h08000014; // 0x40 j 0x14
        dut.instr_rom[6'h14] = 32'h20000007; // 0x50 addi $0,$0,7
        dut.instr_rom[6'h15] = 32'h00015025; // 0x54 or $10,$0,$1

        reset = 1'b1;
        step();
        reset = 1'b0;

        // addi $1,$0,5
        check_val("addi_addr", address, 32'h0);
        check_val("addi_instr", instruction, 32'h20010005);
        check_val("addi_alu", outALU, 32'd5);
        check_val("addi_wrreg", wrRegis, 32'd1);
        check_val("addi_regwrite", regwrite, 32'd1);
        check_val("addi_alusrc", alusrc, 32'd1);
        step();
        // addi $2,$0,3
        check_val("pc_after_addi", address, 32'h4);
        check_val("reg1", dut.u_reg_file.regs_q[1], 32'd5);
        check_val("addi2_alu", outALU, 32'd3);
        step();
        // sub $3,$1,$2
        check_val("sub_data1", data1, 32'd5);
        check_val("sub_data2", data2, 32'd3);
        check_val("sub_alucon", ALUCon, 32'b0110);
        check_val("sub_alu", outALU, 32'd2);
        check_val("sub_wrreg", wrRegis, 32'd3);
        step();
        // slt $4,$2,$1
        check_val("slt_alucon", ALUCon, 32'b0111);
        check_val("slt_alu", outALU, 32'd1);
        step();
        // nor $5,$0,$0
        check_val("nor_alucon", ALUCon, 32'b1100);
        check_val("nor_alu", outALU, 32'hFFFFFFFF);
        check_val("nor_zero", zero, 32'd0);
        step();
        // sw $1,8($0)
        check_val("sw_memwrite", memwrite, 32'd1);
        check_val("sw_regwrite", regwrite, 32'd0);
        check_val("sw_alu", outALU, 32'd8);
        check_val("sw_data2", data2, 32'd5);
        step();
        // lw $6,8($0)
        check_val("lw_dataout", dataOut, 32'd5);
        check_val("lw_memtoreg", memtoreg, 32'd1);
        check_val("lw_memread", memread, 32'd1);
        check_val("lw_wrreg", wrRegis, 32'd6);
        check_val("lw_datatoreg", dataToReg, 32'd5);
        step();
        // and $7,$1,$2
        check_val("reg6", dut.u_reg_file.regs_q[6], 32'd5);
        check_val("and_alucon", ALUCon, 32'b0000);
        check_val("and_alu", outALU, 32'd1);
        step();
        // beq $1,$1,+2 at 0x20
        check_val("beq_addr", address, 32'h20);
        check_val("beq_zero", zero, 32'd1);
        check_val("beq_sel", selBranch, 32'd1);
        check_val("beq_shift", shiftBranch, 32'd8);
        check_val("beq_target", addAddress, 32'h2C);
        step();
        // bne $1,$1,+2 at 0x2C
        check_val("beq_taken_addr", address, 32'h2C);
        check_val("bne_aluop", aluop, 32'b01);
        check_val("bne_sel", selBranch, 32'd0);
        step();
        // jal 0x10 at 0x30
        check_val("bne_not_taken_addr", address, 32'h30);
        check_val("jal_jaddr", jumpAddress, 32'h40);
        check_val("jal_wrreg", wrRegis, 32'd31);
        check_val("jal_datatoreg", dataToReg, 32'h34);
        check_val("jal_jump", jump, 32'd1);
        check_val("jal_jal", jal, 32'd1);
        step();
        // j 0x14 at 0x40
        check_val("jal_target_addr", address, 32'h40);
        check_val("reg31", dut.u_reg_file.regs_q[31], 32'h34);
        check_val("j_regwrite", regwrite, 32'd0);
        check_val("j_jaddr", jumpAddress, 32'h50);
        step();
        // addi $0,$0,7 at 0x50
        check_val("j_target_addr", address, 32'h50);
        check_val("reg31_after_j", dut.u_reg_file.regs_q[31], 32'h34);
        check_val("r0_wrreg", wrRegis, 32'd0);
        check_val("r0_alu", outALU, 32'd7);
        step();
        // or $10,$0,$1 at 0x54
        check_val("or_data1_r0", data1, 32'd0);
        check_val("or_alucon", ALUCon, 32'b0001);
        check_val("or_alu", outALU, 32'd5);
        check_val("reg9_skipped", dut.u_reg_file.regs_q[9], 32'd0);

        // Mid-program reset
        reset = 1'b1;
        step();
        check_val("rst_addr", address, 32'h0);
        check_val("rst_data2", data2, 32'd0);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.u_reg_file.regs_q[i] != 32'd0) nz++;
        check_val("rst_regs_nonzero", nz, 32'd0);
        check_val("rst_ram2", dut.ram_q[2], 32'd0);
        reset = 1'b0;
        step();
        check_val("post_rst_addr", address, 32'h4);
        check_val("post_rst_reg1", dut.u_reg_file.regs_q[1], 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
